duc_fs4: RTL and testbench



---
 rtl/duc_fs4.sv | 113 +++++++++++
 tb/tb_duc_fs4.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/duc_fs4.sv
// fs/4 digital up-converter: 4x polyphase interpolation of complex baseband
// followed by an fs/4 mix to one real IF sample per clk.
module duc_fs4 #(
    parameter int width = 12,
    parameter int SHIFT = 7
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic signed [width-1:0] BaseBand_I,
    input  logic signed [width-1:0] BaseBand_Q,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic signed [width-1:0] IF_Signal,
    output logic                    if_valid,
    output logic                    underflow
);

    localparam int ACC_W  = width + 10;
    localparam int COEF_W = 8;
    localparam int TAPS   = 4;

    typedef logic signed [COEF_W-1:0] coef_t;
    typedef logic signed [width-1:0]  sample_t;
    typedef logic signed [ACC_W-1:0]  acc_t;

    // Symmetric low-pass prototype; index = phase + 4*tap.
    localparam coef_t H [16] = '{
        -8'sd4,  -8'sd9,   -8'sd8,   8'sd8,
         8'sd40,  8'sd80,   8'sd112, 8'sd127,
         8'sd127, 8'sd112,  8'sd80,  8'sd40,
         8'sd8,  -8'sd8,   -8'sd9,  -8'sd4
    };

    localparam acc_t SAT_HI = (acc_t'(1) <<< (width - 1)) - acc_t'(1);
    localparam acc_t SAT_LO = ~SAT_HI;

    logic [1:0] ph;
    sample_t    xi [TAPS];
    sample_t    xq [TAPS];
    logic       primed;

    acc_t       term [TAPS];
    acc_t       acc;
    acc_t       mixed;
    acc_t       shifted;
    sample_t    sat_out;

    assign in_ready = (ph == 2'd3);

    // Even phases filter I, odd phases filter Q; each phase uses its own
    // coefficient subset h[ph + 4*j] against the four most recent samples.
    always_comb begin
        for (int j = 0; j < TAPS; j++) begin
            term[j] = (ph[0] ? acc_t'(xq[j]) : acc_t'(xi[j])) * acc_t'(H[{2'(j), ph}]);
        end
    end

    always_comb begin
        // NOTE: every combinational output gets a value on every path so no latch is inferred.
        acc     = '0;
        mixed   = '0;
        shifted = '0;
        sat_out = '0;

        for (int j = 0; j < TAPS; j++) begin
            acc = acc + term[j];
        end

        // fs/4 carrier: cos = +1,0,-1,0 on I and -sin = 0,-1,0,+1 on Q.
        mixed   = (ph[0] ^ ph[1]) ? -acc : acc;
        shifted = mixed >>> SHIFT;

        if (shifted > SAT_HI) begin
            sat_out = SAT_HI[width-1:0];
        end else if (shifted < SAT_LO) begin
            sat_out = SAT_LO[width-1:0];
        end else begin
            sat_out = shifted[width-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            ph        <= '0;
            // NOTE: the history is a handful of registers that must start clean after reset, so it is cleared explicitly rather than left to power-up state.
            xi        <= '{default: '0};
            xq        <= '{default: '0};
            primed    <= 1'b0;
            IF_Signal <= '0;
            if_valid  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            // NOTE: all state here uses non-blocking assignments so every register samples pre-edge values.
            ph        <= ph + 2'd1;
            IF_Signal <= sat_out;
            if_valid  <= primed;
            underflow <= in_ready && !in_valid;

            if (in_ready) begin
                xi[0] <= in_valid ? BaseBand_I : '0;
                xq[0] <= in_valid ? BaseBand_Q : '0;
                for (int j = 1; j < TAPS; j++) begin
                    xi[j] <= xi[j-1];
                    xq[j] <= xq[j-1];
                end
                if (in_valid) begin
                    primed <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_duc_fs4.sv
// Self-checking bench for duc_fs4: sample-list model checked every cycle,
// plus literal expectations for impulse, DC, saturation, underflow and reset.
module tb_duc_fs4;

    localparam int W     = 12;
    localparam int SHIFT = 7;
    localparam int HC [16] = '{-4, -9, -8, 8, 40, 80, 112, 127,
                               127, 112, 80, 40, 8, -8, -9, -4};
    localparam int IMP [16] = '{-4, 0, 6, 0, 31, 0, -88, 0,
                                99, 0, -63, 0, 6, 0, 7, 0};

    logic                clk = 1'b0;
    logic                rst;
    logic signed [W-1:0] BaseBand_I;
    logic signed [W-1:0] BaseBand_Q;
    logic                in_valid;
    logic                in_ready;
    logic signed [W-1:0] IF_Signal;
    logic                if_valid;
    logic                underflow;

    duc_fs4 #(.width(W), .SHIFT(SHIFT)) dut (
        .clk        (clk),
        .rst        (rst),
        .BaseBand_I (BaseBand_I),
        .BaseBand_Q (BaseBand_Q),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .IF_Signal  (IF_Signal),
        .if_valid   (if_valid),
        .underflow  (underflow)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    // Model state: every accepted (or zero-filled) sample in arrival order.
    int smp_i[$];
    int smp_q[$];
    int m_ph;
    bit primed;
    bit chk_en = 1'b0;
    int exp_if;
    bit exp_valid;
    bit exp_uf;

    int tr_if[$];
    bit tr_uf[$];
    bit tr_vld[$];
    bit tr_rdy[$];

    task automatic check(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int fdiv(input int a, input int d);
        int q;
        q = a / d;
        if ((a % d != 0) && (a < 0)) q = q - 1;
        return q;
    endfunction

    function automatic int model_if(input int k);
        int acc;
        int n;
        int x;
        acc = 0;
        for (int j = 0; j < 4; j++) begin
            n = smp_i.size() - 1 - j;
            x = 0;
            if (n >= 0) x = (k % 2 == 0) ? smp_i[n] : smp_q[n];
            acc = acc + HC[k + 4 * j] * x;
        end
        if (k == 1 || k == 2) acc = -acc;
        acc = fdiv(acc, 1 << SHIFT);
        if (acc > (1 << (W - 1)) - 1) acc = (1 << (W - 1)) - 1;
        if (acc < -(1 << (W - 1))) acc = -(1 << (W - 1));
        return acc;
    endfunction

    always @(posedge clk) begin
        #1;
        if (chk_en) begin
            check("if_signal", IF_Signal, exp_if);
            check("if_valid", if_valid, exp_valid);
            check("underflow", underflow, exp_uf);
            check("in_ready", in_ready, (m_ph == 3));
        end
    end

    // One clk edge: drive at negedge, predict that edge, record outputs after it.
    task automatic cycle(input bit r, input int vi, input int vq, input bit v);
        rst        = r;
        BaseBand_I = W'(vi);
        BaseBand_Q = W'(vq);
        in_valid   = v;
        if (!r) begin
            m_ph = 0;
            smp_i.delete();
            smp_q.delete();
            exp_if    = 0;
            exp_valid = 1'b0;
            exp_uf    = 1'b0;
            primed    = 1'b0;
        end else begin
            exp_if    = model_if(m_ph);
            exp_valid = primed;
            exp_uf    = (m_ph == 3) && !v;
            if (m_ph == 3) begin
                smp_i.push_back(v ? vi : 0);
                smp_q.push_back(v ? vq : 0);
                if (v) primed = 1'b1;
            end
            m_ph = (m_ph + 1) % 4;
        end
        chk_en = 1'b1;
        @(negedge clk);
        tr_if.push_back(int'(IF_Signal));
        tr_uf.push_back(underflow);
        tr_vld.push_back(if_valid);
        tr_rdy.push_back(in_ready);
    endtask

    // Four cycles starting at ph==0; the sample is offered at the ph==3 slot.
    task automatic slot(input int vi, input int vq, input bit v, input bit junk);
        for (int c = 0; c < 3; c++) begin
            cycle(1'b1, junk ? 777 : 0, junk ? -5 : 0, junk);
        end
        cycle(1'b1, vi, vq, v);
    endtask

    task automatic do_reset();
        cycle(1'b0, 0, 0, 1'b0);
        cycle(1'b0, 0, 0, 1'b0);
    endtask

    task automatic clear_trace();
        tr_if.delete();
        tr_uf.delete();
        tr_vld.delete();
        tr_rdy.delete();
    endtask

    task automatic impulse_and_check(input string tag);
        slot(100, 0, 1'b1, 1'b0);
        for (int s = 0; s < 5; s++) slot(0, 0, 1'b1, 1'b0);
        for (int n = 0; n < 16; n++) begin
            check({tag, "_imp"}, tr_if[4 + n], IMP[n]);
        end
        check({tag, "_imp_tail"}, tr_if[20], 0);
        check({tag, "_imp_valid"}, tr_vld[4], 1);
    endtask

    task automatic dc_test(input string tag, input int vi, input int vq,
                           input int e0, input int e1, input int e2, input int e3);
        do_reset();
        clear_trace();
        for (int s = 0; s < 6; s++) slot(vi, vq, 1'b1, 1'b0);
        check({tag, "_k0"}, tr_if[20], e0);
        check({tag, "_k1"}, tr_if[21], e1);
        check({tag, "_k2"}, tr_if[22], e2);
        check({tag, "_k3"}, tr_if[23], e3);
    endtask

    int uf_count;

    initial begin
        rst        = 1'b0;
        BaseBand_I = '0;
        BaseBand_Q = '0;
        in_valid   = 1'b0;
        m_ph       = 0;
        primed     = 1'b0;
        exp_if     = 0;
        exp_valid  = 1'b0;
        exp_uf     = 1'b0;
        @(negedge clk);

        do_reset();
        check("reset_if", IF_Signal, 0);
        check("reset_valid", if_valid, 0);

        clear_trace();
        impulse_and_check("first");

        // Underflow: junk pulses off-slot, one missing sample, then normal flow.
        do_reset();
        clear_trace();
        slot(500, 0, 1'b1, 1'b1);
        slot(0, 0, 1'b0, 1'b1);
        slot(0, 0, 1'b1, 1'b1);
        slot(0, 0, 1'b1, 1'b0);
        uf_count = 0;
        foreach (tr_uf[n]) uf_count += int'(tr_uf[n]);
        check("uf_pulse", tr_uf[7], 1);
        check("uf_count", uf_count, 1);
        check("uf_first_out", tr_if[4], -16);
        check("uf_zero_ins", tr_if[8], 156);
        check("uf_valid_kept", tr_vld[15], 1);

        // Reset in the middle of a stream, at ph==1.
        slot(900, -300, 1'b1, 1'b0);
        cycle(1'b1, 300, 0, 1'b1);
        cycle(1'b0, 300, 0, 1'b1);
        check("mid_rst_if", IF_Signal, 0);
        check("mid_rst_valid", if_valid, 0);
        check("mid_rst_ready", in_ready, 0);
        clear_trace();
        impulse_and_check("after_rst");
        check("rdy_after_1", tr_rdy[0], 0);
        check("rdy_after_2", tr_rdy[1], 0);
        check("rdy_after_3", tr_rdy[2], 1);

        dc_test("dc_i", 1000, 0, 1335, 0, -1368, 0);
        dc_test("dc_q", 0, 1000, 0, -1368, 0, 1335);
        dc_test("sat", 2047, 0, 2047, 0, -2048, 0);
        dc_test("sat_neg", -2048, 0, -2048, 0, 2047, 0);

        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
